// File: rtl/cond_unit.sv
// Condition evaluation and status-flag register for the single-cycle core.
// Optional shadow flag register is built only when COND_FLAG_SHADOW_EN is defined.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_instr_valid,
  input  logic [3:0] i_cond,
  input  logic [1:0] i_flag_write,
  input  logic       i_alu_n,
  input  logic       i_alu_z,
  input  logic       i_alu_co,
  input  logic       i_alu_ovf,
  input  logic       i_reg_write_req,
  input  logic       i_mem_write_req,
  input  logic       i_pc_src_req,
  input  logic       i_flag_save,
  input  logic       i_flag_restore,
  output logic       o_reg_write,
  output logic       o_mem_write,
  output logic       o_pc_src,
  output logic       o_cond_ex,
  output logic       o_cond_illegal,
  output logic [3:0] o_flags
);

  logic [3:0] r_flags;
  logic [3:0] w_flags_next;
  logic       w_n, w_z, w_c, w_v;
  logic       w_cond_ex;
  logic       w_commit;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Evaluated against the registered flags only, never the live ALU outputs.
  always_comb begin
    w_cond_ex = 1'b0;
    case (i_cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = !w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = !w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = !w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = !w_v;
      4'b1000: w_cond_ex = w_c & !w_z;
      4'b1001: w_cond_ex = !w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = !w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  assign w_commit       = i_instr_valid & w_cond_ex;
  assign o_cond_ex      = w_cond_ex;
  assign o_cond_illegal = i_instr_valid & (i_cond == 4'b1111);
  assign o_reg_write    = i_reg_write_req & w_commit;
  assign o_mem_write    = i_mem_write_req & w_commit;
  assign o_pc_src       = i_pc_src_req & w_commit;
  assign o_flags        = r_flags;

  always_comb begin
    w_flags_next = r_flags;
    if (w_commit && i_flag_write[1]) begin
      w_flags_next[3] = i_alu_n;
      w_flags_next[2] = i_alu_z;
    end
    if (w_commit && i_flag_write[0]) begin
      w_flags_next[1] = i_alu_co;
      w_flags_next[0] = i_alu_ovf;
    end
  end

`ifdef COND_FLAG_SHADOW_EN
  logic [3:0] r_shadow;

  // Save and restore are side effects of the instruction, so they share its gating.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flags  <= RESET_FLAGS;
      r_shadow <= RESET_FLAGS;
    end else begin
      if (w_commit && i_flag_save)
        r_shadow <= r_flags;
      if (w_commit && i_flag_restore)
        r_flags <= r_shadow;
      else
        r_flags <= w_flags_next;
    end
  end
`else
  logic w_unused;
  assign w_unused = i_flag_save ^ i_flag_restore;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_flags <= RESET_FLAGS;
    else
      r_flags <= w_flags_next;
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed test-plan steps plus randomized
// stimulus compared every cycle against a behavioural flag/condition model.
module tb_cond_unit;

  localparam logic [3:0] RF = 4'b0000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic [3:0] cond = 4'd0;
  logic [1:0] flag_write = 2'd0;
  logic       alu_n = 1'b0, alu_z = 1'b0, alu_co = 1'b0, alu_ovf = 1'b0;
  logic       rw_req = 1'b0, mw_req = 1'b0, pc_req = 1'b0;
  logic       flag_save = 1'b0, flag_restore = 1'b0;
  logic       reg_write, mem_write, pc_src, cond_ex, cond_illegal;
  logic [3:0] flags;

  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;

  logic [3:0] m_flags = RF;
  logic [3:0] m_shadow = RF;

  cond_unit #(.RESET_FLAGS(RF)) dut (
    .i_clk(clk), .i_reset(reset), .i_instr_valid(instr_valid), .i_cond(cond),
    .i_flag_write(flag_write), .i_alu_n(alu_n), .i_alu_z(alu_z),
    .i_alu_co(alu_co), .i_alu_ovf(alu_ovf), .i_reg_write_req(rw_req),
    .i_mem_write_req(mw_req), .i_pc_src_req(pc_req), .i_flag_save(flag_save),
    .i_flag_restore(flag_restore), .o_reg_write(reg_write),
    .o_mem_write(mem_write), .o_pc_src(pc_src), .o_cond_ex(cond_ex),
    .o_cond_illegal(cond_illegal), .o_flags(flags)
  );

  always #5 clk = ~clk;

  // Pairs of conditions share a base test; the odd member is its negation.
  function automatic bit model_pass(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    case (c >> 1)
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model update at the active edge.
  always @(posedge clk) begin
    logic [3:0] nf;
    logic       go;
    if (reset) begin
      m_flags  = RF;
      m_shadow = RF;
      armed    = 1'b1;
    end else begin
      go = instr_valid && model_pass(m_flags, cond);
      nf = m_flags;
      if (go) begin
        if (flag_write[1]) nf = {alu_n, alu_z, nf[1:0]};
        if (flag_write[0]) nf = {nf[3:2], alu_co, alu_ovf};
`ifdef COND_FLAG_SHADOW_EN
        if (flag_restore) nf = m_shadow;
        if (flag_save) m_shadow = m_flags;
`endif
      end
      m_flags = nf;
    end
  end

  // Every-cycle comparison on the opposite edge.
  always @(negedge clk) begin
    bit p;
    if (armed) begin
      p = model_pass(m_flags, cond);
      check("flags", flags, m_flags);
      check("cond_ex", cond_ex, p);
      check("cond_illegal", cond_illegal, instr_valid && cond == 4'hF);
      check("reg_write", reg_write, rw_req && instr_valid && p);
      check("mem_write", mem_write, mw_req && instr_valid && p);
      check("pc_src", pc_src, pc_req && instr_valid && p);
    end
  end

  task automatic drive(input bit rst, input bit v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] alu, input logic [2:0] req, input bit sv, input bit rs);
    @(posedge clk); #1;
    reset = rst; instr_valid = v; cond = c; flag_write = fw;
    {alu_n, alu_z, alu_co, alu_ovf} = alu;
    {rw_req, mw_req, pc_req} = req;
    flag_save = sv; flag_restore = rs;
    #1;
  endtask

  task automatic idle(input logic [3:0] c);
    drive(0, 0, c, 2'b00, 4'h0, 3'b000, 0, 0);
  endtask

  task automatic setf(input logic [3:0] f);
    drive(0, 1, 4'hE, 2'b11, f, 3'b000, 0, 0);
  endtask

  initial begin
    drive(1, 0, 4'h0, 2'b00, 4'h0, 3'b000, 0, 0);
    idle(4'h0);
    check("reset_flags", flags, RF);
    check("reset_reg_write", reg_write, 0);
    check("reset_illegal", cond_illegal, 0);
    check("reset_cond_ex_eq", cond_ex, 0);

    // SUBS 5-5 then EQ/NE
    drive(0, 1, 4'hE, 2'b11, 4'b0110, 3'b000, 0, 0);
    drive(0, 1, 4'h0, 2'b00, 4'h0, 3'b100, 0, 0);
    check("subs_flags", flags, 4'b0110);
    check("eq_reg_write", reg_write, 1);
    drive(0, 1, 4'h1, 2'b11, 4'b1001, 3'b100, 0, 0);
    check("ne_reg_write", reg_write, 0);
    idle(4'h0);
    check("ne_flags_hold", flags, 4'b0110);

    // Signed comparisons with N=1, V=0
    setf(4'b1000);
    drive(0, 1, 4'hB, 2'b00, 4'h0, 3'b000, 0, 0); check("lt", cond_ex, 1);
    drive(0, 1, 4'hA, 2'b00, 4'h0, 3'b000, 0, 0); check("ge", cond_ex, 0);
    drive(0, 1, 4'hC, 2'b00, 4'h0, 3'b000, 0, 0); check("gt", cond_ex, 0);
    drive(0, 1, 4'hD, 2'b00, 4'h0, 3'b000, 0, 0); check("le", cond_ex, 1);

    // Logic op updates only N/Z
    setf(4'b0011);
    drive(0, 1, 4'hE, 2'b10, 4'b1000, 3'b000, 0, 0);
    idle(4'h0);
    check("logic_nz_only", flags, 4'b1011);

    // Failed condition and bubble
    setf(4'b0100);
    drive(0, 1, 4'h1, 2'b11, 4'b1111, 3'b010, 0, 0);
    check("fail_mem_write", mem_write, 0);
    drive(0, 0, 4'hE, 2'b11, 4'b1111, 3'b010, 0, 0);
    check("bubble_mem_write", mem_write, 0);
    check("fail_flags_hold", flags, 4'b0100);
    idle(4'h0);
    check("bubble_flags_hold", flags, 4'b0100);

    // Illegal condition
    drive(0, 1, 4'hF, 2'b11, 4'b1111, 3'b001, 0, 0);
    check("nv_cond_ex", cond_ex, 0);
    check("nv_illegal", cond_illegal, 1);
    check("nv_pc_src", pc_src, 0);
    idle(4'h0);
    check("nv_flags_hold", flags, 4'b0100);

    // Save/restore sequence (ignored without the shadow build)
    setf(4'b1001);
    drive(0, 1, 4'hE, 2'b11, 4'b0100, 3'b000, 1, 0);
    drive(0, 1, 4'hE, 2'b11, 4'b1111, 3'b000, 0, 1);
    check("save_with_update", flags, 4'b0100);
    idle(4'h0);
`ifdef COND_FLAG_SHADOW_EN
    check("restore_wins", flags, 4'b1001);
`else
    check("restore_ignored", flags, 4'b1111);
`endif
    drive(1, 0, 4'h0, 2'b00, 4'h0, 3'b000, 0, 0);
    drive(0, 1, 4'hE, 2'b00, 4'h0, 3'b000, 0, 1);
    check("mid_reset_flags", flags, RF);
    idle(4'h0);
    check("restore_after_reset", flags, RF);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 7) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), c,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end
    idle(4'h0);
    @(posedge clk); #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
